// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 4-bit character-LCD driver.
package lcd_pkg;

  typedef enum logic [3:0] {
    PWR_WAIT, INIT_NIB, INIT_WAIT, CFG_LOAD, IDLE,
    SETUP_HI, E_HI, GAP, SETUP_LO, E_LO, POST_WAIT
  } lcd_state_e;

  // Which sequence owns the nibble path; decides where E_HI and POST_WAIT go next.
  typedef enum logic [1:0] {PH_INIT, PH_CFG, PH_HOST} lcd_phase_e;

  typedef struct packed {
    logic       cmd;
    logic [7:0] data;
  } lcd_byte_t;

  // Element 0 is the first one sent.
  localparam logic [3:0][3:0] INIT_NIBS = {4'h2, 4'h3, 4'h3, 4'h3};
  localparam logic [3:0][7:0] CFG_BYTES = {8'h01, 8'h0C, 8'h06, 8'h28};

  localparam logic [7:0] OP_CLEAR = 8'h01;
  localparam logic [7:0] OP_HOME  = 8'h02;

  // A zero-length wait would never produce a done pulse, so the minimum is one cycle.
  function automatic logic [19:0] cycles(input int n);
    return (n < 1) ? 20'd1 : 20'(n);
  endfunction

  function automatic logic is_slow_cmd(input logic cmd, input logic [7:0] b);
    return cmd && ((b == OP_CLEAR) || (b == OP_HOME));
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable 20-bit down-counter; oDone pulses in the last cycle of a loaded interval.
module lcd_delay_timer #(
  parameter logic [19:0] RST_COUNT = 20'd1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iLoad,
  input  logic [19:0] iCount,
  output logic        oDone
);

  logic [19:0] cnt;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)            cnt <= RST_COUNT;
    else if (iLoad)        cnt <= iCount;
    else if (cnt != 20'd0) cnt <= cnt - 20'd1;
  end

  // Loading N keeps the owning state for exactly N cycles.
  assign oDone = (cnt == 20'd1);

endmodule

// File: rtl/lcd_nibble_driver.sv
// HD44780 driver: self-runs power-on init and config, then sends host bytes as two nibbles.
module lcd_nibble_driver
  import lcd_pkg::*;
#(
  parameter int T_POWERUP = 750000,
  parameter int T_INIT1   = 205000,
  parameter int T_INIT2   = 5000,
  parameter int T_SETUP   = 2,
  parameter int T_EH      = 12,
  parameter int T_GAP     = 50,
  parameter int T_CMD     = 2000,
  parameter int T_CLR     = 82000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iWrite,
  input  logic [7:0] iData,
  input  logic       iCommand,
  output logic       oReady,
  output logic       oIsInitialized,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic       oLCD_StrataFlashControl,
  output logic [3:0] oLCD_Data
);

  lcd_state_e  state, state_n;
  lcd_phase_e  phase, phase_n;
  lcd_byte_t   hold, hold_n;
  logic [1:0]  init_idx, init_idx_n;
  logic [1:0]  cfg_idx, cfg_idx_n;
  logic        e_n, rs_n;
  logic [3:0]  data_n;
  logic        load, done;
  logic [19:0] load_count;

  assign oLCD_RW                 = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

  lcd_delay_timer #(.RST_COUNT(cycles(T_POWERUP))) u_timer (
    .Clock  (Clock),
    .Reset  (Reset),
    .iLoad  (load),
    .iCount (load_count),
    .oDone  (done)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state          <= PWR_WAIT;
      phase          <= PH_INIT;
      hold           <= '0;
      init_idx       <= 2'd0;
      cfg_idx        <= 2'd0;
      oLCD_E         <= 1'b0;
      oLCD_RS        <= 1'b0;
      oLCD_Data      <= 4'h0;
      oReady         <= 1'b0;
      oIsInitialized <= 1'b0;
    end else begin
      state          <= state_n;
      phase          <= phase_n;
      hold           <= hold_n;
      init_idx       <= init_idx_n;
      cfg_idx        <= cfg_idx_n;
      oLCD_E         <= e_n;
      oLCD_RS        <= rs_n;
      oLCD_Data      <= data_n;
      oReady         <= (state_n == IDLE);
      oIsInitialized <= oIsInitialized | (state_n == IDLE);
    end
  end

  always_comb begin
    state_n    = state;
    phase_n    = phase;
    hold_n     = hold;
    init_idx_n = init_idx;
    cfg_idx_n  = cfg_idx;

    case (state)
      PWR_WAIT:  if (done) state_n = INIT_NIB;
      INIT_NIB:  if (done) state_n = E_HI;
      E_HI:      if (done) state_n = (phase == PH_INIT) ? INIT_WAIT : GAP;
      INIT_WAIT: if (done) begin
        if (init_idx == 2'd3) begin
          state_n     = CFG_LOAD;
          phase_n     = PH_CFG;
          cfg_idx_n   = 2'd0;
          hold_n.cmd  = 1'b1;
          hold_n.data = CFG_BYTES[0];
        end else begin
          state_n    = INIT_NIB;
          init_idx_n = init_idx + 2'd1;
        end
      end
      CFG_LOAD:  if (done) state_n = SETUP_HI;
      IDLE:      if (iWrite) begin
        state_n     = SETUP_HI;
        phase_n     = PH_HOST;
        hold_n.cmd  = iCommand;
        hold_n.data = iData;
      end
      SETUP_HI:  if (done) state_n = E_HI;
      GAP:       if (done) state_n = SETUP_LO;
      SETUP_LO:  if (done) state_n = E_LO;
      E_LO:      if (done) state_n = POST_WAIT;
      POST_WAIT: if (done) begin
        if ((phase == PH_CFG) && (cfg_idx != 2'd3)) begin
          state_n     = CFG_LOAD;
          cfg_idx_n   = cfg_idx + 2'd1;
          hold_n.cmd  = 1'b1;
          hold_n.data = CFG_BYTES[cfg_idx + 2'd1];
        end else begin
          state_n = IDLE;
        end
      end
      default:   state_n = PWR_WAIT;
    endcase

    // Bus values only change on entry to a setup state, so they are frozen across E.
    e_n    = (state_n == E_HI) || (state_n == E_LO);
    rs_n   = oLCD_RS;
    data_n = oLCD_Data;
    case (state_n)
      INIT_NIB: begin rs_n = 1'b0;        data_n = INIT_NIBS[init_idx_n]; end
      SETUP_HI: begin rs_n = ~hold_n.cmd; data_n = hold_n.data[7:4];     end
      SETUP_LO: begin rs_n = ~hold_n.cmd; data_n = hold_n.data[3:0];     end
      default: ;
    endcase

    load = (state_n != state);
    case (state_n)
      PWR_WAIT:                     load_count = cycles(T_POWERUP);
      INIT_NIB, SETUP_HI, SETUP_LO: load_count = cycles(T_SETUP);
      E_HI, E_LO:                   load_count = cycles(T_EH);
      GAP:                          load_count = cycles(T_GAP);
      INIT_WAIT: begin
        case (init_idx)
          2'd0:    load_count = cycles(T_INIT1);
          2'd1:    load_count = cycles(T_INIT2);
          default: load_count = cycles(T_CMD);
        endcase
      end
      POST_WAIT: load_count = is_slow_cmd(hold_n.cmd, hold_n.data) ? cycles(T_CLR)
                                                                   : cycles(T_CMD);
      default:   load_count = 20'd1;
    endcase
  end

endmodule

// File: tb/tb_lcd_nibble_driver.sv
// Directed bench for lcd_nibble_driver with shortened timing parameters.
module tb_lcd_nibble_driver;

  localparam int P = 20, I1 = 10, I2 = 5, C = 4, CL = 8, S = 1, EH = 2, G = 3;
  localparam int INIT_READY = P + 4*(S+EH) + I1 + I2 + 2*C
                            + 4*(1 + 2*S + 2*EH + G) + 3*C + CL;   // 115

  logic       Clock = 1'b0, Reset = 1'b1, iWrite = 1'b0, iCommand = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       oReady, oIsInitialized, oLCD_E, oLCD_RS, oLCD_RW, oLCD_StrataFlashControl;
  logic [3:0] oLCD_Data;

  lcd_nibble_driver #(
    .T_POWERUP(P), .T_INIT1(I1), .T_INIT2(I2), .T_SETUP(S),
    .T_EH(EH), .T_GAP(G), .T_CMD(C), .T_CLR(CL)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iWrite(iWrite), .iData(iData), .iCommand(iCommand),
    .oReady(oReady), .oIsInitialized(oIsInitialized), .oLCD_E(oLCD_E), .oLCD_RS(oLCD_RS),
    .oLCD_RW(oLCD_RW), .oLCD_StrataFlashControl(oLCD_StrataFlashControl),
    .oLCD_Data(oLCD_Data)
  );

  always #5 Clock = ~Clock;

  int         n_cmp = 0, n_bad = 0, cyc = 0, stable_err = 0;
  logic       e_prev = 1'b0;
  logic [4:0] bus_prev = 5'h0;
  logic [4:0] pulses[$];
  int         pulse_cyc[$];

  always @(posedge Clock) cyc <= cyc + 1;

  // Log every E rising edge as {RS, nibble} and flag bus changes while E is high.
  always @(negedge Clock) begin
    e_prev   <= oLCD_E;
    bus_prev <= {oLCD_RS, oLCD_Data};
    if (oLCD_E && !e_prev) begin
      pulses.push_back({oLCD_RS, oLCD_Data});
      pulse_cyc.push_back(cyc);
    end
    if (oLCD_E && e_prev && ({oLCD_RS, oLCD_Data} != bus_prev)) stable_err <= stable_err + 1;
  end

  task automatic wait_ready(output int busy);
    busy = 0;
    while (oReady !== 1'b1 && busy < 500) begin
      busy++;
      @(negedge Clock);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic cmd, output int acc);
    @(negedge Clock);
    iData = b; iCommand = cmd; iWrite = 1'b1;
    @(negedge Clock);
    iWrite = 1'b0;
    acc = cyc;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    #2;
    n_cmp++;
    if ({oLCD_E, oLCD_RS, oLCD_RW, oLCD_Data} !== 7'h00) begin
      n_bad++; $display("FAIL reset_bus: got %b expected 0000000", {oLCD_E, oLCD_RS, oLCD_RW, oLCD_Data});
    end
    n_cmp++;
    if (oLCD_StrataFlashControl !== 1'b1) begin
      n_bad++; $display("FAIL reset_sf: got %b expected 1", oLCD_StrataFlashControl);
    end
    n_cmp++;
    if ({oReady, oIsInitialized} !== 2'b00) begin
      n_bad++; $display("FAIL reset_ready_init: got %b expected 00", {oReady, oIsInitialized});
    end
  endtask

  task automatic test_init(input string tag);
    logic [4:0] exp [12] = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08,
                             5'h00, 5'h06, 5'h00, 5'h0C, 5'h00, 5'h01};
    int n = 0, split = 0;
    repeat (3) @(negedge Clock);
    pulses.delete(); pulse_cyc.delete();
    Reset = 1'b1;
    while (oReady !== 1'b1 && n < 2000) begin
      @(negedge Clock);
      n++;
      if (oIsInitialized !== oReady) split++;
      if (n == 30 || n == 80) begin iData = 8'hAA; iCommand = 1'b0; iWrite = 1'b1; end
      if (n == 31 || n == 81) iWrite = 1'b0;
    end
    n_cmp++;
    if (n !== INIT_READY) begin
      n_bad++; $display("FAIL %s_ready_cycle: got %0d expected %0d", tag, n, INIT_READY);
    end
    n_cmp++;
    if (split !== 0 || oIsInitialized !== 1'b1) begin
      n_bad++; $display("FAIL %s_init_flag: split=%0d init=%b expected 0/1", tag, split, oIsInitialized);
    end
    @(negedge Clock); #1;
    n_cmp++;
    if (pulses.size() !== 12) begin
      n_bad++; $display("FAIL %s_pulse_count: got %0d expected 12", tag, pulses.size());
    end
    for (int i = 0; i < 12 && i < pulses.size(); i++) begin
      n_cmp++;
      if (pulses[i] !== exp[i]) begin
        n_bad++; $display("FAIL %s_pulse%0d: got %h expected %h", tag, i, pulses[i], exp[i]);
      end
    end
  endtask

  task automatic test_data_write();
    int acc, busy;
    pulses.delete(); pulse_cyc.delete();
    send(8'h41, 1'b0, acc);
    wait_ready(busy);
    @(negedge Clock); #1;
    n_cmp++;
    if (busy !== 13) begin n_bad++; $display("FAIL data_busy: got %0d expected 13", busy); end
    n_cmp++;
    if (pulses.size() !== 2) begin
      n_bad++; $display("FAIL data_pulse_count: got %0d expected 2", pulses.size());
    end else begin
      n_cmp++;
      if (pulses[0] !== 5'h14 || pulses[1] !== 5'h11) begin
        n_bad++; $display("FAIL data_nibbles: got %h %h expected 14 11", pulses[0], pulses[1]);
      end
      n_cmp++;
      if (pulse_cyc[0] - acc !== S || pulse_cyc[1] - acc !== 2*S + EH + G) begin
        n_bad++; $display("FAIL data_e_timing: got %0d %0d expected %0d %0d",
                          pulse_cyc[0] - acc, pulse_cyc[1] - acc, S, 2*S + EH + G);
      end
    end
  endtask

  task automatic test_cmd_clear();
    int acc, busy;
    pulses.delete(); pulse_cyc.delete();
    send(8'h01, 1'b1, acc);
    wait_ready(busy);
    @(negedge Clock); #1;
    n_cmp++;
    if (busy !== 17) begin n_bad++; $display("FAIL clr_busy: got %0d expected 17", busy); end
    n_cmp++;
    if (pulses.size() !== 2 || pulses[0] !== 5'h00 || pulses[1] !== 5'h01) begin
      n_bad++; $display("FAIL clr_nibbles: got n=%0d first=%h expected n=2 00 01",
                        pulses.size(), (pulses.size() > 0) ? pulses[0] : 5'h1F);
    end
  endtask

  task automatic test_ignore();
    int busy;
    pulses.delete(); pulse_cyc.delete();
    @(negedge Clock);
    iData = 8'h35; iCommand = 1'b0; iWrite = 1'b1;
    @(negedge Clock);
    iData = 8'hFF; iCommand = 1'b1;
    repeat (3) @(negedge Clock);
    iWrite = 1'b0;
    wait_ready(busy);
    repeat (4) @(negedge Clock); #1;
    n_cmp++;
    if (busy + 3 !== 13) begin n_bad++; $display("FAIL ign_busy: got %0d expected 13", busy + 3); end
    n_cmp++;
    if (pulses.size() !== 2 || pulses[0] !== 5'h13 || pulses[1] !== 5'h15) begin
      n_bad++; $display("FAIL ign_nibbles: got n=%0d first=%h expected n=2 13 15",
                        pulses.size(), (pulses.size() > 0) ? pulses[0] : 5'h1F);
    end
    n_cmp++;
    if (oReady !== 1'b1) begin n_bad++; $display("FAIL ign_not_queued: ready=%b expected 1", oReady); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp [4] = '{5'h14, 5'h18, 5'h14, 5'h19};
    int b1, b2;
    pulses.delete(); pulse_cyc.delete();
    @(negedge Clock);
    iData = 8'h48; iCommand = 1'b0; iWrite = 1'b1;
    @(negedge Clock);
    iData = 8'h49;
    wait_ready(b1);
    @(negedge Clock);
    n_cmp++;
    if (oReady !== 1'b0) begin n_bad++; $display("FAIL b2b_second_accept: ready=%b expected 0", oReady); end
    iWrite = 1'b0;
    wait_ready(b2);
    @(negedge Clock); #1;
    n_cmp++;
    if (b1 !== 13 || b2 !== 13) begin
      n_bad++; $display("FAIL b2b_busy: got %0d %0d expected 13 13", b1, b2);
    end
    n_cmp++;
    if (pulses.size() !== 4) begin
      n_bad++; $display("FAIL b2b_pulse_count: got %0d expected 4", pulses.size());
    end
    for (int i = 0; i < 4 && i < pulses.size(); i++) begin
      n_cmp++;
      if (pulses[i] !== exp[i]) begin
        n_bad++; $display("FAIL b2b_pulse%0d: got %h expected %h", i, pulses[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc, n = 0;
    send(8'h41, 1'b0, acc);
    while (oLCD_E !== 1'b1 && n < 50) begin @(negedge Clock); n++; end
    n_cmp++;
    if (n >= 50) begin n_bad++; $display("FAIL rst_mid_e_seen: E=%b expected 1", oLCD_E); end
    #2 Reset = 1'b0;
    #1;
    n_cmp++;
    if ({oLCD_E, oReady, oIsInitialized} !== 3'b000) begin
      n_bad++; $display("FAIL rst_mid_flags: got %b expected 000", {oLCD_E, oReady, oIsInitialized});
    end
    n_cmp++;
    if (oLCD_StrataFlashControl !== 1'b1 || {oLCD_RS, oLCD_Data} !== 5'h00) begin
      n_bad++; $display("FAIL rst_mid_bus: sf=%b bus=%h expected 1 00",
                        oLCD_StrataFlashControl, {oLCD_RS, oLCD_Data});
    end
    test_init("replay");
  endtask

  task automatic test_bus_stable();
    n_cmp++;
    if (stable_err !== 0) begin
      n_bad++; $display("FAIL bus_stable_during_e: got %0d changes expected 0", stable_err);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_init("init");
    test_data_write();
    test_cmd_clear();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    test_bus_stable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_nibble_driver.md
# lcd_nibble_driver

Character-LCD driver that sits directly downstream of the MiniAlu `LCD` instruction. It accepts one byte per `iWrite`/`oReady` handshake and runs the HD44780 power-on initialisation on its own. Each accepted byte is sent to the Spartan-3E starter-board LCD as two 4-bit nibbles with the required enable-pulse and settle timing. It exposes the same write/ready/initialised contract the CPU pipeline stalls on.

## Interface
Parameters (cycle counts at 50 MHz; the bench overrides them with small values):
- `T_POWERUP`, default 750000: power-on wait before the first nibble (15 ms).
- `T_INIT1`, default 205000: wait after the 1st init nibble (4.1 ms).
- `T_INIT2`, default 5000: wait after the 2nd init nibble (100 µs).
- `T_SETUP`, default 2: RS/data stable before E rises.
- `T_EH`, default 12: E high width (240 ns).
- `T_GAP`, default 50: E low time between the upper and lower nibble (1 µs).
- `T_CMD`, default 2000: post-byte wait (40 µs); also used after init nibbles 3 and 4.
- `T_CLR`, default 82000: post-byte wait for commands 0x01 and 0x02 (1.64 ms).

Ports:
- `Clock` in 1: sole clock.
- `Reset` in 1: asynchronous, active-low reset.
- `iWrite` in 1: write request, sampled only while `oReady`=1.
- `iData` in 8: byte to send.
- `iCommand` in 1: 1 = instruction (RS=0), 0 = character data (RS=1).
- `oReady` out 1: driver idle and able to accept a byte.
- `oIsInitialized` out 1: init sequence complete; sticky until reset.
- `oLCD_E` out 1: LCD enable strobe.
- `oLCD_RS` out 1: register select.
- `oLCD_RW` out 1: constant 0 (write-only).
- `oLCD_StrataFlashControl` out 1: constant 1 (StrataFlash disabled).
- `oLCD_Data` out 4: nibble bus SF_D[11:8].

## Operation
- Reset values:
  - `oLCD_E`=0, `oLCD_RS`=0, `oLCD_RW`=0, `oLCD_Data`=0.
  - `oLCD_StrataFlashControl`=1.
  - `oReady`=0, `oIsInitialized`=0.
  - State is PWR_WAIT.
- States: PWR_WAIT, INIT_NIB, INIT_WAIT, CFG_LOAD, IDLE, SETUP_HI, E_HI, GAP, SETUP_LO, E_LO, POST_WAIT.
- Init phase:
  - PWR_WAIT runs for T_POWERUP cycles.
  - Then four single nibbles 0x3, 0x3, 0x3, 0x2, each with RS=0 and the sequence T_SETUP, then E for T_EH.
  - Waits after each nibble: T_INIT1, T_INIT2, T_CMD, T_CMD.
- Config phase (CFG_LOAD): the driver itself sends four full bytes with RS=0: 0x28, 0x06, 0x0C, 0x01. They use the same path as a host byte.
- Entry to IDLE:
  - Only after the 0x01 clear wait (T_CLR) has expired.
  - On entry, `oIsInitialized` and `oReady` rise together.
- Byte path:
  - SETUP_HI drives `iData[7:4]` and RS.
  - E_HI holds the upper nibble with E=1.
  - GAP holds E=0.
  - SETUP_LO drives `iData[3:0]`.
  - E_LO holds the lower nibble with E=1.
  - POST_WAIT holds E=0.
- POST_WAIT length is T_CLR when the byte is an instruction equal to 0x01 or 0x02, otherwise T_CMD.
- `iData` and `iCommand` are captured into a holding register on acceptance. Later input changes have no effect on the byte in flight.
- `iWrite` while `oReady`=0 (busy or still initialising) is ignored and not queued.
- `oLCD_Data` and `oLCD_RS` hold their last values outside E pulses. They never change while E=1.

## Timing
- Acceptance: a rising edge with `iWrite`=1 and `oReady`=1. `oReady` is 0 from the next cycle.
- Busy time per byte: `oReady` stays low for exactly T_SETUP + T_EH + T_GAP + T_SETUP + T_EH + T_wait cycles, where T_wait is T_CMD or T_CLR. At defaults this is 2078 cycles.
- E pulse edges relative to acceptance:
  - Upper-nibble E rises T_SETUP cycles after acceptance.
  - Lower-nibble E rises T_SETUP+T_EH+T_GAP+T_SETUP cycles after acceptance.
- Back-to-back writes: the earliest next acceptance is on the cycle `oReady` returns to 1. No bubble is required.
- Total init-to-ready cycle count is deterministic and is the sum of all of the above. The bench computes it from the parameters.
- Reset asserted mid-byte or mid-init:
  - All outputs return immediately (asynchronously) to their reset values.
  - Counters clear.
  - The full init sequence restarts after release.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `lcd_pkg` holds:
  - the state enum;
  - the init nibble constants (0x3, 0x3, 0x3, 0x2);
  - the config byte list (0x28, 0x06, 0x0C, 0x01);
  - the opcodes 0x01 and 0x02 that need T_CLR.
- One sub-module, `lcd_delay_timer`:
  - 20-bit loadable down-counter with `iLoad`, `iCount[19:0]` and a one-cycle `oDone` pulse.
  - The FSM loads it on every state entry.
- Index counters: a 2-bit init-nibble index and a 2-bit config-byte index, both local to the FSM.

## Test plan
- Init with small parameters (POWERUP=20, INIT1=10, INIT2=5, CMD=4, CLR=8, SETUP=1, EH=2, GAP=3), no writes:
  - exactly 4 single E pulses carrying nibbles 3, 3, 3, 2 with RS=0;
  - then 8 pulses spelling 2,8 0,6 0,C 0,1;
  - `oReady` and `oIsInitialized` rise on the same cycle at the computed count.
- Data write 0x41 with `iCommand`=0:
  - RS=1, nibbles 4 then 1;
  - `oReady` low for 1+2+3+1+2+4=13 cycles.
- Command write 0x01:
  - RS=0, nibbles 0 then 1;
  - busy for 17 cycles (T_CLR path).
- `iWrite` pulses during init and mid-byte: ignored, with no extra E pulses. A change of `iData` after acceptance does not alter the nibbles on the bus.
- Back-to-back 0x48, 0x49 with `iWrite` held high: second acceptance on the exact cycle `oReady` returns to 1; no lost or duplicated byte.
- Reset asserted during E_HI of a byte:
  - immediately E=0, `oReady`=0, `oIsInitialized`=0, StrataFlash=1;
  - after release the full init sequence replays identically.
